alu_4bits: RTL and testbench



---
 rtl/alu_4bits.sv | 97 +++++++++
 tb/tb_alu_4bits.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_4bits.sv
// rtl/alu_4bits.sv - dual-rail 4-bit add/subtract ALU with registered result and flags
//
// Purpose: sums or subtracts two dual-rail encoded 4-bit operands and registers
// the dual-rail result together with signed-overflow, negative and zero flags.
// Each pair of rails is 00 = NULL, 01 = logical 0, 10 = logical 1, 11 = illegal.
// A complete DATA wavefront registers a result, a complete NULL wavefront
// registers all-NULL outputs, and anything else holds the outputs.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset (outputs forced to NULL)
//   a      in   8  operand A, 4 dual-rail bits, bit 0 on rails [1:0]
//   b      in   8  operand B, 4 dual-rail bits
//   opr    in   2  operation, dual-rail: logical 0 = add, logical 1 = subtract
//   soma   out  8  result R, 4 dual-rail bits
//   of     out  2  signed overflow flag, dual-rail
//   neg    out  2  negative flag (R[3]), dual-rail
//   zero   out  2  zero flag (R == 0), dual-rail

module alu_4bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] opr,
  output logic [7:0] soma,
  output logic [1:0] of,
  output logic [1:0] neg,
  output logic [1:0] zero
);

  logic [3:0] a_v;
  logic [3:0] b_v;
  logic       opr_v;
  logic [3:0] b_x;
  logic [3:0] r;
  logic       of_v;
  logic       is_data;
  logic       is_null;
  logic [7:0] soma_enc;

  // The high rail of each pair carries the logical value once the pair is valid.
  always_comb begin
    a_v = 4'd0;
    b_v = 4'd0;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = a[2*i+1];
      b_v[i] = b[2*i+1];
    end
    opr_v = opr[1];
  end

  // A pair is valid DATA only when exactly one rail is high.
  always_comb begin
    is_data = opr[1] ^ opr[0];
    for (int i = 0; i < 4; i++) begin
      is_data = is_data & (a[2*i+1] ^ a[2*i]) & (b[2*i+1] ^ b[2*i]);
    end
    is_null = ~|{a, b, opr};
  end

  // Subtraction as A + ~B + 1; the carry-out is deliberately dropped.
  always_comb begin
    b_x  = opr_v ? ~b_v : b_v;
    r    = a_v + b_x + {3'b000, opr_v};
    // Same-sign effective operands producing a result of the other sign.
    of_v = (a_v[3] == b_x[3]) && (r[3] != a_v[3]);
  end

  always_comb begin
    soma_enc = 8'h00;
    for (int i = 0; i < 4; i++) begin
      soma_enc[2*i+1 -: 2] = r[i] ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soma <= 8'h00;
      of   <= 2'b00;
      neg  <= 2'b00;
      zero <= 2'b00;
    end else if (is_data) begin
      soma <= soma_enc;
      of   <= of_v ? 2'b10 : 2'b01;
      neg  <= r[3] ? 2'b10 : 2'b01;
      zero <= (r == 4'd0) ? 2'b10 : 2'b01;
    end else if (is_null) begin
      soma <= 8'h00;
      of   <= 2'b00;
      neg  <= 2'b00;
      zero <= 2'b00;
    end
    // Incomplete wavefronts hold every output.
  end

endmodule

// File: tb/tb_alu_4bits.sv
// tb/tb_alu_4bits.sv - self-checking bench for alu_4bits with an integer reference model
module tb_alu_4bits;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] opr;
  logic [7:0] soma;
  logic [1:0] of;
  logic [1:0] neg;
  logic [1:0] zero;

  int checks;
  int failures;

  localparam logic [13:0] ALL_NULL = 14'h0000;

  alu_4bits dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .opr  (opr),
    .soma (soma),
    .of   (of),
    .neg  (neg),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] enc4(input int v);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < 4; i++) e[2*i +: 2] = ((v >> i) & 1) ? 2'b10 : 2'b01;
    return e;
  endfunction

  function automatic logic [1:0] enc1(input bit v);
    return v ? 2'b10 : 2'b01;
  endfunction

  // Reference: signed integer arithmetic, overflow = result outside [-8,7].
  function automatic logic [13:0] model(input int av, input int bv, input bit sub);
    int sa, sb, sr, r4;
    sa = (av >= 8) ? av - 16 : av;
    sb = (bv >= 8) ? bv - 16 : bv;
    sr = sub ? sa - sb : sa + sb;
    r4 = sr & 15;
    return {enc4(r4), enc1(sr > 7 || sr < -8), enc1(r4 >= 8), enc1(r4 == 0)};
  endfunction

  task automatic check(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = {soma, of, neg, zero};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge register, sample 1 ns later.
  task automatic apply(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] ov);
    @(negedge clk);
    a = av; b = bv; opr = ov;
    @(posedge clk);
    #1;
  endtask

  logic [13:0] held;
  logic [17:0] vec;
  int          av, bv, mask, pair;
  bit          sub;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; a = 8'h00; b = 8'h00; opr = 2'b00;
    #12;
    check("reset_null", ALL_NULL);
    @(negedge clk); rst_n = 1'b1;
    apply(8'h00, 8'h00, 2'b00);
    check("null_after_reset", ALL_NULL);

    apply(8'b01011010, 8'b01011001, 2'b01);
    check("add_3_2", {8'b01100110, 2'b01, 2'b01, 2'b01});
    apply(8'h00, 8'h00, 2'b00);
    check("null_return", ALL_NULL);
    apply(8'b01011010, 8'b01100110, 2'b10);
    check("sub_3_5", {8'b10101001, 2'b01, 2'b10, 2'b01});
    apply(8'h00, 8'h00, 2'b00);
    apply(8'b01101010, 8'b01010110, 2'b01);
    check("add_ovf_7_1", {8'b10010101, 2'b10, 2'b10, 2'b01});
    apply(8'h00, 8'h00, 2'b00);
    apply(8'b01100110, 8'b01100110, 2'b10);
    check("sub_zero_5_5", {8'b01010101, 2'b01, 2'b01, 2'b10});
    apply(8'h00, 8'h00, 2'b00);
    apply(enc4(8), enc4(1), 2'b10);
    check("sub_ovf_m8_1", model(8, 1, 1'b1));

    // Back-to-back DATA without a NULL still updates.
    apply(enc4(9), enc4(4), 2'b01);
    check("back_to_back", model(9, 4, 1'b0));

    // Partial wavefront after NULL holds NULL.
    apply(8'h00, 8'h00, 2'b00);
    apply(enc4(6), 8'h00, 2'b00);
    check("partial_hold_null_1", ALL_NULL);
    apply(enc4(6), 8'h00, 2'b01);
    check("partial_hold_null_2", ALL_NULL);

    // Illegal pair holds a DATA result across several clocks.
    apply(enc4(6), enc4(3), 2'b01);
    held = model(6, 3, 1'b0);
    check("data_before_illegal", held);
    for (int k = 0; k < 3; k++) begin
      apply(enc4(1), enc4(2) | 8'b0000_1100, 2'b01);
      check("illegal_hold", held);
    end

    // Randomised DATA / NULL / incomplete sequence against the model.
    for (int n = 0; n < 60; n++) begin
      av  = $urandom_range(0, 15);
      bv  = $urandom_range(0, 15);
      sub = 1'($urandom_range(0, 1));
      apply(enc4(av), enc4(bv), enc1(sub));
      held = model(av, bv, sub);
      check("rand_data", held);
      vec = {enc4(av ^ 5), enc4(bv ^ 3), enc1(!sub)};
      if ($urandom_range(0, 1) == 0) begin
        mask = $urandom_range(1, 510); // proper non-empty subset of 9 pairs nulled
        for (int p = 0; p < 9; p++) if ((mask >> p) & 1) vec[2*p +: 2] = 2'b00;
      end else begin
        pair = $urandom_range(0, 8);
        vec[2*pair +: 2] = 2'b11;
      end
      apply(vec[17:10], vec[9:2], vec[1:0]);
      check("rand_incomplete_hold", held);
      apply(8'h00, 8'h00, 2'b00);
      check("rand_null", ALL_NULL);
    end

    // Asynchronous reset mid-wavefront, before the next rising edge.
    apply(enc4(7), enc4(7), 2'b01);
    check("pre_reset_data", model(7, 7, 1'b0));
    @(negedge clk);
    a = enc4(2); b = enc4(9); opr = 2'b10;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_mid_cycle", ALL_NULL);
    @(posedge clk); #1;
    check("reset_held_over_edge", ALL_NULL);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("resume_after_reset", model(2, 9, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
